// File: rtl/halli_pkg.sv
// Shared types for the Halli Galli round controller: FSM state encoding,
// player encoding and one-hot ringer codes used on the score strobe.
package halli_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_TURN,
    S_DEAL,
    S_SETTLE,
    S_JUDGE,
    S_HOLD,
    S_FINAL,
    S_OVER
  } state_t;

  localparam logic PLAYER_P1 = 1'b0;
  localparam logic PLAYER_P2 = 1'b1;

  localparam logic [1:0] RINGER_NONE = 2'b00;
  localparam logic [1:0] RINGER_P1   = 2'b01;
  localparam logic [1:0] RINGER_P2   = 2'b10;

endpackage

// File: rtl/halli_bell_arbiter.sv
// Bell arbitration: resolves same-cycle rings with a rotating tie priority
// and holds the accepted ringer until the FSM has judged it.
module halli_bell_arbiter
  import halli_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       bell_p1,
  input  logic       bell_p2,
  input  logic       take,
  input  logic       clear,
  output logic       ring_any,
  output logic       pending,
  output logic [1:0] ringer
);

  logic       pending_q, pending_d;
  logic [1:0] ringer_q, ringer_d;
  logic       tie_pri_q, tie_pri_d;
  logic       tie;
  logic [1:0] win_who;

  assign ring_any = bell_p1 | bell_p2;
  assign tie      = bell_p1 & bell_p2;
  assign pending  = pending_q;
  assign ringer   = ringer_q;

  // On a tie the priority holder wins and priority passes to the loser.
  always_comb begin
    win_who   = RINGER_NONE;
    pending_d = pending_q;
    ringer_d  = ringer_q;
    tie_pri_d = tie_pri_q;
    if (tie) begin
      win_who = (tie_pri_q == PLAYER_P2) ? RINGER_P2 : RINGER_P1;
    end else if (bell_p1) begin
      win_who = RINGER_P1;
    end else if (bell_p2) begin
      win_who = RINGER_P2;
    end
    if (clear) begin
      pending_d = 1'b0;
      ringer_d  = RINGER_NONE;
    end else if (take && ring_any) begin
      pending_d = 1'b1;
      ringer_d  = win_who;
      if (tie) begin
        tie_pri_d = ~tie_pri_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= 1'b0;
      ringer_q  <= RINGER_NONE;
      tie_pri_q <= PLAYER_P1;
    end else begin
      pending_q <= pending_d;
      ringer_q  <= ringer_d;
      tie_pri_q <= tie_pri_d;
    end
  end

endmodule

// File: rtl/halli_round_ctrl.sv
// Halli Galli game sequencer: deals cards, tracks whose turn it is, and
// emits one registered scoring strobe per accepted bell ring.
module halli_round_ctrl
  import halli_pkg::*;
#(
  parameter int DECK_SIZE  = 40,
  parameter int SETTLE_CYC = 4,
  parameter int HOLD_CYC   = 25_000_000,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             flip_p1,
  input  logic             flip_p2,
  input  logic             bell_p1,
  input  logic             bell_p2,
  input  logic             match,
  output logic             rnd_en,
  output logic             whose,
  output logic             score_en,
  output logic [1:0]       score_who,
  output logic             score_right,
  output logic             clr_game,
  output logic             game_over,
  output logic [CNT_W-1:0] dealt
);

  localparam int TIMER_W = $clog2(HOLD_CYC + 1);
  localparam logic [TIMER_W-1:0] TIMER_MAX   = TIMER_W'(HOLD_CYC);
  localparam logic [TIMER_W-1:0] SETTLE_LAST = TIMER_W'(SETTLE_CYC - 1);
  localparam logic [TIMER_W-1:0] HOLD_LAST   = TIMER_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0]   DECK_FULL   = CNT_W'(DECK_SIZE);

  state_t             state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [CNT_W-1:0]   dealt_q, dealt_d;
  logic               whose_q, whose_d;
  logic               defer_q, defer_d;
  logic               rnd_en_q, rnd_en_d;
  logic               score_en_q, score_en_d;
  logic [1:0]         score_who_q, score_who_d;
  logic               score_right_q, score_right_d;
  logic               clr_game_q, clr_game_d;
  logic               game_over_q, game_over_d;

  logic       take, clear, ring_any, pending, flip_mine;
  logic [1:0] ringer;

  halli_bell_arbiter u_arb (
    .clk      (clk),
    .rst      (rst),
    .bell_p1  (bell_p1),
    .bell_p2  (bell_p2),
    .take     (take),
    .clear    (clear),
    .ring_any (ring_any),
    .pending  (pending),
    .ringer   (ringer)
  );

  assign flip_mine = (whose_q == PLAYER_P2) ? flip_p2 : flip_p1;

  // defer_q remembers a ring taken during SETTLE so the turn passes at HOLD exit.
  always_comb begin
    state_d       = state_q;
    timer_d       = (timer_q == TIMER_MAX) ? timer_q : timer_q + 1'b1;
    dealt_d       = dealt_q;
    whose_d       = whose_q;
    defer_d       = defer_q;
    rnd_en_d      = 1'b0;
    score_en_d    = 1'b0;
    score_who_d   = RINGER_NONE;
    score_right_d = 1'b0;
    clr_game_d    = 1'b0;
    take          = 1'b0;
    clear         = 1'b0;
    unique case (state_q)
      S_IDLE, S_OVER: begin
        if (start) begin
          clr_game_d = 1'b1;
          dealt_d    = '0;
          whose_d    = PLAYER_P1;
          defer_d    = 1'b0;
          state_d    = S_TURN;
        end
      end
      S_TURN: begin
        if (ring_any && dealt_q != '0) begin
          take    = 1'b1;
          state_d = S_JUDGE;
        end else if (flip_mine) begin
          state_d = S_DEAL;
        end
      end
      S_DEAL: begin
        rnd_en_d = 1'b1;
        if (dealt_q < DECK_FULL) dealt_d = dealt_q + 1'b1;
        timer_d  = '0;
        state_d  = S_SETTLE;
      end
      S_SETTLE: begin
        take = ring_any && !pending;
        if (timer_q == SETTLE_LAST) begin
          if (pending || take) begin
            defer_d = 1'b1;
            state_d = S_JUDGE;
          end else begin
            whose_d = ~whose_q;
            if (dealt_q == DECK_FULL) begin
              timer_d = '0;
              state_d = S_FINAL;
            end else begin
              state_d = S_TURN;
            end
          end
        end
      end
      S_JUDGE: begin
        score_en_d    = 1'b1;
        score_who_d   = ringer;
        score_right_d = match;
        clear         = 1'b1;
        timer_d       = '0;
        state_d       = S_HOLD;
      end
      S_HOLD: begin
        if (timer_q == HOLD_LAST) begin
          if (defer_q) whose_d = ~whose_q;
          defer_d = 1'b0;
          state_d = (dealt_q == DECK_FULL) ? S_OVER : S_TURN;
        end
      end
      S_FINAL: begin
        if (ring_any) begin
          take    = 1'b1;
          state_d = S_JUDGE;
        end else if (timer_q == HOLD_LAST) begin
          state_d = S_OVER;
        end
      end
      default: state_d = S_IDLE;
    endcase
    game_over_d = (state_d == S_OVER);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      timer_q       <= '0;
      dealt_q       <= '0;
      whose_q       <= PLAYER_P1;
      defer_q       <= 1'b0;
      rnd_en_q      <= 1'b0;
      score_en_q    <= 1'b0;
      score_who_q   <= RINGER_NONE;
      score_right_q <= 1'b0;
      clr_game_q    <= 1'b0;
      game_over_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      dealt_q       <= dealt_d;
      whose_q       <= whose_d;
      defer_q       <= defer_d;
      rnd_en_q      <= rnd_en_d;
      score_en_q    <= score_en_d;
      score_who_q   <= score_who_d;
      score_right_q <= score_right_d;
      clr_game_q    <= clr_game_d;
      game_over_q   <= game_over_d;
    end
  end

  assign rnd_en      = rnd_en_q;
  assign whose       = whose_q;
  assign score_en    = score_en_q;
  assign score_who   = score_who_q;
  assign score_right = score_right_q;
  assign clr_game    = clr_game_q;
  assign game_over   = game_over_q;
  assign dealt       = dealt_q;

endmodule
